// File: rtl/dsp_seq_ctrl.sv
// Stream-to-DSP sequencer: gathers A/B operand vectors, starts the DSP, then streams the result out.
// Define DSP_SEQ_TIMEOUT_EN to add a WAIT-state timeout with a sticky timeout_err flag.
module dsp_seq_ctrl #(
    parameter int DW = 32,
    parameter int N  = 8
`ifdef DSP_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic [1:0]           in_op,
    output logic                 dsp_start,
    output logic [1:0]           dsp_operation,
    output logic [N-1:0][DW-1:0] dsp_A,
    output logic [N-1:0][DW-1:0] dsp_B,
    input  logic [N-1:0][DW-1:0] dsp_result,
    input  logic                 dsp_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int CW = $clog2(2 * N);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [1:0]           op_q, op_d;
    logic [N-1:0][DW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic                 done_q;
    logic                 in_fire;
    logic                 done_edge;
    logic                 timeout_hit;

    assign in_fire   = in_valid && in_ready;
    // A done level left over from the previous command must fall and rise again to count.
    assign done_edge = (state_q == S_WAIT) && dsp_done && !done_q;

`ifdef DSP_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;

    assign timeout_hit = (state_q == S_WAIT) && !done_edge && (wait_cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        wait_cnt_d = '0;
        if (state_q == S_WAIT && !done_edge && !timeout_hit) wait_cnt_d = wait_cnt_q + 1'b1;
        err_d = err_q;
        if (timeout_hit) err_d = 1'b1;
        else if (state_q == S_IDLE && in_fire) err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: if (in_fire) begin
                op_d    = in_op;
                a_d[0]  = in_data;
                cnt_d   = CW'(1);
                state_d = S_LOAD;
            end
            S_LOAD: if (in_fire) begin
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CW'(i))     a_d[i] = in_data;
                    if (cnt_q == CW'(N + i)) b_d[i] = in_data;
                end
                if (cnt_q == CW'(2 * N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (done_edge) begin
                    res_d   = dsp_result;
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: if (out_ready) begin
                if (idx_q == IW'(N - 1)) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            op_q    <= '0;
            done_q  <= 1'b0;
            // NOTE: operand and result storage is reset too, because it drives outputs that must read 0.
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            done_q  <= dsp_done;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        dsp_start = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        unique case (state_q)
            S_IDLE, S_LOAD: in_ready = 1'b1;
            S_START:        dsp_start = 1'b1;
            S_DRAIN: begin
                out_valid = 1'b1;
                out_last  = (idx_q == IW'(N - 1));
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IW'(i)) out_data = res_q[i];
                end
            end
            default: ;
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign dsp_operation = op_q;
    assign dsp_A         = a_q;
    assign dsp_B         = b_q;
endmodule
